// File: rtl/tt_mux_sel_ctrl.sv
// Spine select/enable controller: synchronised pad strobes drive a registered select
// address and an enable that is dropped before any address change. Optional direct load: TT_SEL_DIRECT_LOAD_EN.
module tt_mux_sel_ctrl #(
  parameter int SEL_W         = 10,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_sel_rst_n,
  input  logic             ctrl_sel_inc,
  input  logic             ctrl_ena,
`ifdef TT_SEL_DIRECT_LOAD_EN
  input  logic             sel_load,
  input  logic [SEL_W-1:0] sel_data,
`endif
  output logic [SEL_W-1:0] spine_sel,
  output logic             spine_ena,
  output logic             busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);

  typedef enum logic [1:0] {DIS, SETTLE, ACT} state_e;
  // Encoding order is the request priority: clear > load > increment.
  typedef enum logic [1:0] {RQ_NONE, RQ_INC, RQ_LOAD, RQ_CLR} req_e;

  logic [SYNC_STAGES-1:0] r_rst_sync, r_inc_sync, r_ena_sync;
  logic                   r_inc_d;
  state_e                 r_state;
  req_e                   r_pend;
  logic [SEL_W-1:0]       r_pend_data;
  logic [CNT_W-1:0]       r_cnt;

  logic             w_sel_rst_s, w_inc_s, w_ena_s, w_inc_pulse, w_load;
  logic [SEL_W-1:0] w_load_data, w_apply_data, w_sel_nxt;
  req_e             w_req, w_apply;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rst_sync <= '0;
      r_inc_sync <= '0;
      r_ena_sync <= '0;
      r_inc_d    <= 1'b0;
    end else begin
      r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], ctrl_sel_rst_n};
      r_inc_sync <= {r_inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
      r_ena_sync <= {r_ena_sync[SYNC_STAGES-2:0], ctrl_ena};
      r_inc_d    <= w_inc_s;
    end
  end

  assign w_sel_rst_s = r_rst_sync[SYNC_STAGES-1];
  assign w_inc_s     = r_inc_sync[SYNC_STAGES-1];
  assign w_ena_s     = r_ena_sync[SYNC_STAGES-1];
  assign w_inc_pulse = w_inc_s & ~r_inc_d;

`ifdef TT_SEL_DIRECT_LOAD_EN
  assign w_load      = sel_load;
  assign w_load_data = sel_data;
`else
  assign w_load      = 1'b0;
  assign w_load_data = '0;
`endif

  always_comb begin
    w_req = RQ_NONE;
    if (!w_sel_rst_s)     w_req = RQ_CLR;
    else if (w_load)      w_req = RQ_LOAD;
    else if (w_inc_pulse) w_req = RQ_INC;
  end

  // A deferred request merges with one arriving on its apply edge; the higher priority wins.
  always_comb begin
    w_apply      = w_req;
    w_apply_data = w_load_data;
    if (r_pend > w_req) begin
      w_apply      = r_pend;
      w_apply_data = r_pend_data;
    end
  end

  always_comb begin
    w_sel_nxt = spine_sel;
    case (w_apply)
      RQ_CLR:  w_sel_nxt = '0;
      RQ_LOAD: w_sel_nxt = w_apply_data;
      RQ_INC:  w_sel_nxt = spine_sel + SEL_W'(1);
      default: w_sel_nxt = spine_sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= DIS;
      r_pend      <= RQ_NONE;
      r_pend_data <= '0;
      r_cnt       <= '0;
      spine_sel   <= '0;
      spine_ena   <= 1'b0;
    end else begin
      case (r_state)
        DIS: begin
          if (w_apply != RQ_NONE) begin
            spine_sel <= w_sel_nxt;
            r_pend    <= RQ_NONE;
          end else if (w_ena_s) begin
            if (SETTLE_CYCLES == 0) begin
              r_state   <= ACT;
              spine_ena <= 1'b1;
            end else begin
              r_state <= SETTLE;
              r_cnt   <= CNT_W'(SETTLE_CYCLES);
            end
          end
        end
        SETTLE: begin
          if (w_req != RQ_NONE) begin
            r_state     <= DIS;
            r_pend      <= w_req;
            r_pend_data <= w_load_data;
          end else if (!w_ena_s) begin
            r_state <= DIS;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state   <= ACT;
            spine_ena <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ACT: begin
          if (w_req != RQ_NONE) begin
            r_state     <= DIS;
            spine_ena   <= 1'b0;
            r_pend      <= w_req;
            r_pend_data <= w_load_data;
          end else if (!w_ena_s) begin
            r_state   <= DIS;
            spine_ena <= 1'b0;
          end
        end
        default: begin
          r_state   <= DIS;
          spine_ena <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (r_state == SETTLE) || (r_pend != RQ_NONE);

endmodule

// File: tb/tb_tt_mux_sel_ctrl.sv
// Bench for tt_mux_sel_ctrl: directed scenarios plus random strobes against a
// run-length reference model (enable after SETTLE+1 consecutive quiet, enabled edges).
module tb_tt_mux_sel_ctrl;
  localparam int W  = 10;
  localparam int S  = 2;
  localparam int ST = 4;
  localparam int NE = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0, ctrl_sel_rst_n = 1'b0, ctrl_sel_inc = 1'b0, ctrl_ena = 1'b0;
  logic tb_ld = 1'b0;
  logic [W-1:0] tb_ldd = '0;
  logic [W-1:0] spine_sel;
  logic spine_ena, busy;

  always #5 clk = ~clk;

  tt_mux_sel_ctrl #(.SEL_W(W), .SYNC_STAGES(S), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena),
`ifdef TT_SEL_DIRECT_LOAD_EN
    .sel_load(tb_ld), .sel_data(tb_ldd),
`endif
    .spine_sel(spine_sel), .spine_ena(spine_ena), .busy(busy));

  int total = 0, bad = 0, k = 0;
  bit a_rst[NE], a_sr[NE], a_en[NE], a_inc[NE], a_ld[NE];
  int a_ldd[NE];
  int m_sel, m_run, m_pend, m_pdata, last_rst;
  bit m_ena, m_busy;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, k, obs, exp);
    end
  endtask

  function automatic int synced(input bit v, input int idx);
    return (idx > last_rst) ? int'(v) : 0;
  endfunction

  task automatic apply_req(input int rq, input int d);
    if (rq == 3)      m_sel = 0;
    else if (rq == 2) m_sel = d;
    else if (rq == 1) m_sel = (m_sel + 1) % (1 << W);
  endtask

  // rq codes: 3 clear, 2 load, 1 increment, 0 none (numeric order = priority)
  task automatic model_edge(input int kk);
    int sr, es, is_, id, rq;
    if (!a_rst[kk]) begin
      last_rst = kk; m_sel = 0; m_run = 0; m_pend = 0; m_pdata = 0;
      m_ena = 0; m_busy = 0;
      return;
    end
    sr  = synced(a_sr[kk-S], kk-S);
    es  = synced(a_en[kk-S], kk-S);
    is_ = synced(a_inc[kk-S], kk-S);
    id  = synced(a_inc[kk-1-S], kk-1-S);
    rq = 0;
    if (sr == 0)               rq = 3;
    else if (a_ld[kk])         rq = 2;
    else if (is_ == 1 && id == 0) rq = 1;
    if (m_pend != 0) begin
      if (rq >= m_pend) apply_req(rq, a_ldd[kk]);
      else              apply_req(m_pend, m_pdata);
      m_pend = 0; m_run = 0;
    end else if (rq != 0) begin
      if (m_run >= 1) begin m_pend = rq; m_pdata = a_ldd[kk]; end
      else apply_req(rq, a_ldd[kk]);
      m_run = 0;
    end else begin
      m_run = (es != 0) ? m_run + 1 : 0;
    end
    m_ena  = (m_run >= ST + 1);
    m_busy = (m_run >= 1 && m_run <= ST) || (m_pend != 0);
  endtask

  task automatic tick();
    if (k >= NE - 1) begin
      $display("FAIL edge_budget got=%0d exp=<%0d", k, NE);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "edge budget exhausted");
    end
    a_rst[k] = rst_n; a_sr[k] = ctrl_sel_rst_n; a_en[k] = ctrl_ena;
    a_inc[k] = ctrl_sel_inc; a_ld[k] = tb_ld; a_ldd[k] = int'(tb_ldd);
    @(posedge clk); #1;
    model_edge(k);
    chk("sel", int'(spine_sel), m_sel);
    chk("ena", int'(spine_ena), int'(m_ena));
    chk("busy", int'(busy), int'(m_busy));
    k++;
  endtask

  task automatic pulse_inc(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_sel_inc = 1'b1; tick(); tick();
      ctrl_sel_inc = 1'b0; tick(); tick();
    end
  endtask

  task automatic wait_ena(input bit val, input int lim, input string tag);
    for (int i = 0; i < lim && spine_ena != val; i++) tick();
    chk(tag, int'(spine_ena), int'(val));
  endtask

  initial begin
    int fall, rise, bcnt, seen, t0;
    last_rst = 0;
    // reset state
    tick(); tick();
    chk("rst_sel", int'(spine_sel), 0);
    chk("rst_ena", int'(spine_ena), 0);
    chk("rst_busy", int'(busy), 0);

    // enable latency and SETTLE busy window
    rst_n = 1; ctrl_sel_rst_n = 1; ctrl_ena = 1;
    t0 = k; rise = -1; bcnt = 0;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      tick();
      if (busy) bcnt++;
      if (spine_ena) rise = k;
    end
    chk("ena_latency", rise - t0, S + 1 + ST);
    chk("settle_busy", bcnt, ST);
    chk("sel_at_ena", int'(spine_sel), 0);

    // 37 increments while disabled
    ctrl_ena = 0;
    wait_ena(1'b0, 10, "disable");
    seen = 0;
    for (int i = 0; i < 37; i++) begin
      pulse_inc(1);
      if (spine_ena) seen = 1;
    end
    tick(); tick(); tick();
    chk("inc37", int'(spine_sel), 37);
    chk("inc37_noena", seen, 0);

    // deferred increment from ACT at sel=5
    ctrl_sel_rst_n = 0; repeat (4) tick();
    ctrl_sel_rst_n = 1; repeat (4) tick();
    pulse_inc(5);
    ctrl_ena = 1;
    wait_ena(1'b1, 20, "act_at5");
    chk("sel5", int'(spine_sel), 5);
    fall = -1; rise = -1;
    for (int i = 0; i < 16; i++) begin
      ctrl_sel_inc = (i < 2);
      tick();
      if (fall < 0 && !spine_ena) begin
        fall = k; chk("defer_hold", int'(spine_sel), 5);
      end else if (fall >= 0 && k == fall + 1) begin
        chk("defer_upd", int'(spine_sel), 6);
      end else if (fall >= 0 && rise < 0 && spine_ena) begin
        rise = k;
      end
    end
    chk("defer_fell", int'(fall >= 0), 1);
    chk("reena", rise - (fall + 1), ST + 1);

    // wrap from 1023, then clear during SETTLE
    ctrl_ena = 0; ctrl_sel_rst_n = 0; repeat (4) tick();
    ctrl_sel_rst_n = 1; repeat (4) tick();
    pulse_inc(1023);
    chk("sel1023", int'(spine_sel), 1023);
    pulse_inc(1);
    chk("wrap0", int'(spine_sel), 0);
    chk("wrap_nox", int'($isunknown(spine_sel)), 0);
    ctrl_ena = 1;
    for (int i = 0; i < 10 && !busy; i++) tick();
    chk("settle_seen", int'(busy), 1);
    ctrl_sel_rst_n = 0; seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (spine_ena) seen = 1; end
    chk("clr_noena", seen, 0);
    chk("clr_sel", int'(spine_sel), 0);

    // reset while an increment is pending
    ctrl_sel_rst_n = 1; ctrl_ena = 0; repeat (6) tick();
    pulse_inc(3);
    ctrl_ena = 1;
    wait_ena(1'b1, 20, "act_at3");
    ctrl_sel_inc = 1;
    for (int i = 0; i < 6 && spine_ena; i++) tick();
    chk("pend_busy", int'(busy), 1);
    rst_n = 0; ctrl_sel_inc = 0; tick();
    chk("prst_sel", int'(spine_sel), 0);
    chk("prst_ena", int'(spine_ena), 0);
    chk("prst_busy", int'(busy), 0);
    rst_n = 1; repeat (12) tick();
    chk("prst_noinc", int'(spine_sel), 0);

`ifdef TT_SEL_DIRECT_LOAD_EN
    wait_ena(1'b1, 20, "act_load");
    ctrl_sel_inc = 1; tick(); tick();
    tb_ld = 1; tb_ldd = 10'h2A5; tick();
    chk("load_fall", int'(spine_ena), 0);
    tb_ld = 0; ctrl_sel_inc = 0; tick();
    chk("load_wins", int'(spine_sel), 'h2A5);
`endif

    // random strobes against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) ctrl_ena = ~ctrl_ena;
      ctrl_sel_rst_n = ($urandom_range(59) != 0);
      if ($urandom_range(2) == 0) ctrl_sel_inc = ~ctrl_sel_inc;
      rst_n = ($urandom_range(299) != 0);
`ifdef TT_SEL_DIRECT_LOAD_EN
      tb_ld = ($urandom_range(19) == 0);
      tb_ldd = W'($urandom);
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
